// File: rtl/pwm_pkg.sv
// Shared constants for the PWM core: default widths, default dead time and
// the reset value of the period shadow register.
package pwm_pkg;

   localparam int PWM_N_DEF    = 7;
   localparam int PWM_DEAD_DEF = 2;

   // Reset period for the default width: the longest period the counter allows.
   localparam logic [PWM_N_DEF-1:0] PWM_PERIOD_RST = {PWM_N_DEF{1'b1}};

   // Reset period for an arbitrary width n (all ones), narrowed by the caller.
   function automatic logic [31:0] period_rst(input int n);
      period_rst = (32'd1 << n) - 32'd1;
   endfunction

endpackage

// File: rtl/pwm_deadband.sv
// Dead-time generator: turns the raw PWM into a complementary pair with DEAD
// cycles of both outputs low after every raw edge. Built only when
// PWM_COMPLEMENTARY_EN is defined.
module pwm_deadband
   import pwm_pkg::*;
#(
   parameter int DEAD = PWM_DEAD_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic pwm_out,
   output logic pwm_n
);

   localparam int            DW      = (DEAD < 1) ? 1 : $clog2(DEAD + 1);
   localparam logic [DW-1:0] DT_LOAD = DW'(DEAD);
   localparam logic [DW-1:0] DT_ZERO = {DW{1'b0}};
   localparam logic [DW-1:0] DT_ONE  = DW'(1);

   logic          raw_d_r;
   logic [DW-1:0] dt_r;
   logic [DW-1:0] dt_s;
   logic          p_s;
   logic          n_s;

   // Reload the down-counter on any raw edge; outputs follow raw only once it has drained.
   always_comb begin
      dt_s = dt_r;
      p_s  = 1'b0;
      n_s  = 1'b0;
      if (raw != raw_d_r) begin
         dt_s = DT_LOAD;
      end else if (dt_r != DT_ZERO) begin
         dt_s = dt_r - DT_ONE;
      end else begin
         dt_s = dt_r;
      end
      if (dt_s == DT_ZERO) begin
         p_s = raw;
         n_s = ~raw;
      end else begin
         p_s = 1'b0;
         n_s = 1'b0;
      end
   end

   // Register the dead-time state and both outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         raw_d_r <= 1'b0;
         dt_r    <= DT_ZERO;
         pwm_out <= 1'b0;
         pwm_n   <= 1'b0;
      end else begin
         raw_d_r <= raw;
         dt_r    <= dt_s;
         pwm_out <= p_s;
         pwm_n   <= n_s;
      end
   end

endmodule

// File: rtl/pwm_core.sv
// PWM core: N-bit counter with double-buffered duty/period. Writes land in
// pending registers and are applied at the next wrap, so a period is never
// cut short by a reconfiguration. Optional macro PWM_COMPLEMENTARY_EN adds
// the complementary output pwm_n with a dead-time gap.
module pwm_core
   import pwm_pkg::*;
#(
   parameter int N    = PWM_N_DEF,
   parameter int DEAD = PWM_DEAD_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         ena,
   input  logic [N-1:0] duty,
   input  logic [N-1:0] period,
   input  logic         wr,
   output logic         pending,
   output logic         pwm_out,
   output logic         period_end
`ifdef PWM_COMPLEMENTARY_EN
   ,
   output logic         pwm_n
`endif
);

   localparam logic [N-1:0] PERIOD_RST = N'(period_rst(N));
   localparam logic [N-1:0] ZERO       = {N{1'b0}};
   localparam logic [N-1:0] ONE        = N'(1);

   logic [N-1:0] cnt_r;
   logic [N-1:0] duty_pend_r;
   logic [N-1:0] period_pend_r;
   logic [N-1:0] duty_sh_r;
   logic [N-1:0] period_sh_r;
   logic         pending_r;
   logic         pwm_raw_r;
   logic         wrap_s;

   // period_end marks the wrap cycle itself, so it cannot be registered. Under
   // reset cnt=0 and period_sh=all-ones, so it is 0 whenever rst_n is low.
   assign wrap_s     = ena & (cnt_r == period_sh_r);
   assign period_end = wrap_s;
   assign pending    = pending_r;

   // Free-running counter: wraps to 0 at period_sh, holds while disabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= ZERO;
      end else if (wrap_s) begin
         cnt_r <= ZERO;
      end else if (ena) begin
         cnt_r <= cnt_r + ONE;
      end else begin
         cnt_r <= cnt_r;
      end
   end

   // Capture every write into the pending registers; the last write wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         duty_pend_r   <= ZERO;
         period_pend_r <= ZERO;
      end else if (wr) begin
         duty_pend_r   <= duty;
         period_pend_r <= period;
      end else begin
         duty_pend_r   <= duty_pend_r;
         period_pend_r <= period_pend_r;
      end
   end

   // Shadow update at the wrap; a write on the wrap cycle bypasses the pending stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         duty_sh_r   <= ZERO;
         period_sh_r <= PERIOD_RST;
         pending_r   <= 1'b0;
      end else if (wrap_s && wr) begin
         duty_sh_r   <= duty;
         period_sh_r <= period;
         pending_r   <= 1'b0;
      end else if (wrap_s && pending_r) begin
         duty_sh_r   <= duty_pend_r;
         period_sh_r <= period_pend_r;
         pending_r   <= 1'b0;
      end else if (wr) begin
         duty_sh_r   <= duty_sh_r;
         period_sh_r <= period_sh_r;
         pending_r   <= 1'b1;
      end else begin
         duty_sh_r   <= duty_sh_r;
         period_sh_r <= period_sh_r;
         pending_r   <= pending_r;
      end
   end

   // Raw PWM level, one cycle behind the counter; plain N-bit unsigned compare.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_raw_r <= 1'b0;
      end else begin
         pwm_raw_r <= ena & (cnt_r < duty_sh_r);
      end
   end

`ifdef PWM_COMPLEMENTARY_EN
   pwm_deadband #(
      .DEAD (DEAD)
   ) u_deadband (
      .clk     (clk),
      .rst_n   (rst_n),
      .raw     (pwm_raw_r),
      .pwm_out (pwm_out),
      .pwm_n   (pwm_n)
   );
`else
   assign pwm_out = pwm_raw_r;

   // Dead time only matters for the complementary pair; nothing is built here.
   if (DEAD < 0) begin : g_dead_unused
   end
`endif

endmodule

// File: tb/tb_pwm_core.sv
// Directed bench for pwm_core: a cycle model built from the period/shadow
// rules is compared every cycle, and whole-period measurements are pinned to
// hand-computed lengths and high-times.
module tb_pwm_core;

   localparam int N    = 7;
   localparam int PRST = 127;
`ifdef PWM_COMPLEMENTARY_EN
   localparam int DT = 2;
`else
   localparam int DT = 0;
`endif

   logic         clk    = 1'b0;
   logic         rst_n  = 1'b0;
   logic         ena    = 1'b0;
   logic         wr     = 1'b0;
   logic [N-1:0] duty   = 7'd0;
   logic [N-1:0] period = 7'd0;
   logic         pending;
   logic         pwm_out;
   logic         period_end;
`ifdef PWM_COMPLEMENTARY_EN
   logic         pwm_n;
`endif

   int n_vec = 0;
   int n_err = 0;

   // model state: position in period, active settings, queued write
   int m_phase, m_duty, m_per, m_pd, m_pp;
   bit m_pend, m_pwm;
   bit h_p1, h_n1, h_p2, h_n2;

   always #5 clk = ~clk;

   pwm_core #(.N(N), .DEAD(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .duty       (duty),
      .period     (period),
      .wr         (wr),
      .pending    (pending),
      .pwm_out    (pwm_out),
      .period_end (period_end)
`ifdef PWM_COMPLEMENTARY_EN
      ,
      .pwm_n      (pwm_n)
`endif
   );

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // per-cycle compare against the model, then advance the model with this cycle's inputs
   always @(negedge clk) begin
      bit exp_pe;
      bit nxt_pwm;
      if (!rst_n) begin
         check("reset pwm_out", pwm_out, 0);
         check("reset period_end", period_end, 0);
         check("reset pending", pending, 0);
`ifdef PWM_COMPLEMENTARY_EN
         check("reset pwm_n", pwm_n, 0);
`endif
         m_phase = 0; m_duty = 0; m_per = PRST; m_pd = 0; m_pp = 0;
         m_pend = 1'b0; m_pwm = 1'b0;
         h_p1 = 1'b0; h_n1 = 1'b0; h_p2 = 1'b0; h_n2 = 1'b0;
      end else begin
         exp_pe = ena && (m_phase == m_per);
         check("period_end", period_end, exp_pe);
         check("pending", pending, m_pend);
`ifdef PWM_COMPLEMENTARY_EN
         check("overlap", pwm_out && pwm_n, 0);
         if (pwm_out && !h_p1) check("gap before pwm_out rise", h_p1 | h_n1 | h_p2 | h_n2, 0);
         if (pwm_n && !h_n1)   check("gap before pwm_n rise", h_p1 | h_n1 | h_p2 | h_n2, 0);
         h_p2 = h_p1; h_n2 = h_n1; h_p1 = pwm_out; h_n1 = pwm_n;
`else
         check("pwm_out", pwm_out, m_pwm);
`endif
         nxt_pwm = ena && (m_phase < m_duty);
         if (ena) m_phase = exp_pe ? 0 : (m_phase + 1) % (PRST + 1);
         if (exp_pe && wr) begin
            m_duty = int'(duty); m_per = int'(period); m_pend = 1'b0;
         end else if (exp_pe && m_pend) begin
            m_duty = m_pd; m_per = m_pp; m_pend = 1'b0;
         end
         if (wr) begin
            m_pd = int'(duty); m_pp = int'(period);
            if (!exp_pe) m_pend = 1'b1;
         end
         m_pwm = nxt_pwm;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write(input logic [N-1:0] d, input logic [N-1:0] p);
      tick();
      wr = 1'b1; duty = d; period = p;
      tick();
      wr = 1'b0;
   endtask

   task automatic wait_pe();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (period_end) begin
            ok = 1'b1;
            break;
         end
      end
      check("period_end within budget", ok, 1);
   endtask

   // count cycles and high samples up to and including the next period_end
   task automatic measure(input bit do_wait, output int len, output int hi);
      len = 0;
      hi  = 0;
      if (do_wait) wait_pe();
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         len++;
         if (pwm_out) hi++;
         if (period_end) break;
      end
   endtask

   initial begin
      int len, hi;
      // reset, default 128-cycle period, duty 0
      repeat (3) @(posedge clk);
      #1;
      check("rst pwm_out", pwm_out, 0);
      check("rst pending", pending, 0);
      check("rst period_end", period_end, 0);
      rst_n = 1'b1; ena = 1'b1;
      measure(1'b0, len, hi);
      check("default period len", len, 128);
      check("default period high", hi, 0);
      measure(1'b0, len, hi);
      check("default period len #2", len, 128);
      check("default period high #2", hi, 0);

      // mid-period write waits for the wrap
      repeat (10) tick();
      write(7'd32, 7'd99);
      @(negedge clk);
      check("pending after mid write", pending, 1);
      measure(1'b1, len, hi);
      check("32/99 len", len, 100);
      check("32/99 high", hi, 32 - DT);
      check("pending cleared", pending, 0);

      // write on the wrap cycle goes straight to the shadows
      tick();
      repeat (99) tick();
      wr = 1'b1; duty = 7'd10; period = 7'd19;
      tick();
      wr = 1'b0;
      check("pending after wrap write", pending, 0);
      measure(1'b0, len, hi);
      check("10/19 len", len, 20);
      check("10/19 high", hi, 10 - DT);
      measure(1'b0, len, hi);
      check("10/19 len #2", len, 20);
      check("10/19 high #2", hi, 10 - DT);

      // duty boundaries
      write(7'd0, 7'd99);
      measure(1'b1, len, hi);
      check("duty0 len", len, 100);
      check("duty0 high", hi, 0);
      write(7'd120, 7'd99);
      wait_pe();
      measure(1'b1, len, hi);
      check("duty120 len", len, 100);
      check("duty120 high", hi, 100);

      // disable: output low, write still accepted
      tick();
      ena = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      check("ena0 pwm_out", pwm_out, 0);
      check("ena0 period_end", period_end, 0);
      write(7'd32, 7'd99);
      ena = 1'b1;
      repeat (3) tick();
      check("pending held over ena0", pending, 1);
      check("pwm_out back high", pwm_out, 1);

      // asynchronous reset mid-period drops the pending write
      #1;
      rst_n = 1'b0;
      #1;
      check("async pwm_out", pwm_out, 0);
      check("async pending", pending, 0);
      check("async period_end", period_end, 0);
`ifdef PWM_COMPLEMENTARY_EN
      check("async pwm_n", pwm_n, 0);
`endif
      repeat (2) tick();
      rst_n = 1'b1;
      measure(1'b0, len, hi);
      check("post-reset len", len, 128);
      check("post-reset high", hi, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
